bus_arbiter4: RTL and testbench
===============================

Name: bus_arbiter4

Overview:
- Round-robin arbiter sharing one WIDTH-bit datapath among four requesters.
- Sequences which source drives the shared bus.
- Issues one-hot grants and a 2-bit select, and steers the chosen source onto dout.
- Sits in front of the shared register/bus path and holds ownership for a multi-cycle transaction.

Parameters:
- WIDTH, 32, data width of din0..din3 and dout.
- MAX_HOLD, 16, maximum consecutive owned cycles before forced release. Used only when BUS_ARB_TIMEOUT_EN is defined; legal range 2..65535.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request per requester; level, held until done.
- done  input  4  per-requester end-of-transaction strobe; only the owner's bit is honoured.
- din0..din3  input  WIDTH each  requester data.
- dout  output  WIDTH  data of current owner; 0 when not busy (combinational from sel/busy/din).
- grant  output  4  registered one-hot grant; all-zero when idle.
- sel  output  2  registered index of owner; pairs with grant.
- busy  output  1  registered; 1 while any grant is asserted.
- timeout  output  1  registered one-cycle pulse on forced release; constant 0 without the macro.

Behaviour:
- Reset (async on rst_n low, immediate):
  - grant=0, sel=0, busy=0, timeout=0.
  - State IDLE; last_winner=3, so requester 0 wins first.
- Round-robin pick: first set bit of the candidate mask, scanning last_winner+1, +2, +3, +4 (mod 4).
  - last_winner updates to the winner whenever a grant is issued.
- State IDLE:
  - If req!=0 at an edge, that edge loads grant/sel/busy for the winner and moves to OWN.
  - Latency from req high to grant: 1 cycle.
- State OWN, owner k:
  - Ownership holds while req[k]=1 and done[k]=0.
  - A release condition is done[k]=1, or req[k]=0 (request withdrawn).
  - On release, with the candidate mask = current req: if the mask is nonzero, the next winner is granted at the same edge, with no idle cycle. Owner k may re-win only if it is the sole requester.
  - On release with no requests: grant=0, busy=0, back to IDLE. sel keeps its last value.
  - done bits of non-owners are ignored. New requests never pre-empt the owner.
- grant is always one-hot or zero, and sel always equals the index of the set grant bit.
- dout = din[sel] when busy=1, else all zeros. No extra latency.
- Reset mid-transaction: grant drops asynchronously. After reset release the first winner is requester 0 (when requesting).

Optional Feature:
- BUS_ARB_TIMEOUT_EN defined:
  - A hold counter clears on every new grant and increments each OWN cycle.
  - When it reaches MAX_HOLD-1 with no release condition, a forced release occurs at that edge.
  - On forced release, the candidate mask is req with the owner's bit cleared.
    - Mask nonzero: grant the next winner and pulse timeout=1 for one cycle.
    - Mask zero: the owner keeps the bus, the counter restarts, and no timeout pulse is issued.
  - done[k] or req[k] drop in the same cycle as expiry is a normal release; no timeout pulse.
- Not defined: no counter, timeout tied to 0, ownership unbounded.

Test Plan:
- Reset, then req=4'b1111 held, done pulsed for each owner after 3 cycles -> grant sequence 0001,0010,0100,1000,0001 with no idle gap. sel follows 0,1,2,3,0.
- Only req[2]=1, din2=32'hA5A5_0002 -> grant=0100, sel=2, busy=1 one cycle later, dout=32'hA5A5_0002. done[2] with req[2] dropped -> grant=0, busy=0, dout=0 next cycle.
- Owner 1 active, req[3] asserted, done[3] pulsed -> no change; owner 1 keeps grant until done[1], then grant=1000 at the same edge.
- rst_n pulled low while grant=0100 -> grant=0, busy=0 immediately. After release with req=1111 -> first grant=0001.
- BUS_ARB_TIMEOUT_EN, MAX_HOLD=4, req=0011, owner 0 never asserts done -> after 4 owned cycles grant=0010 and timeout=1 for exactly one cycle. With req=0001 only -> owner 0 retained, timeout stays 0.
- Without macro, same stimulus held 100 cycles -> grant stays 0001, timeout stays 0.

Source files
------------

// File: rtl/bus_arbiter4.sv
// rtl/bus_arbiter4.sv - 4-way round-robin bus arbiter with steered data path (option: BUS_ARB_TIMEOUT_EN)
module bus_arbiter4 #(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [3:0]       done,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    output logic [WIDTH-1:0] dout,
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             timeout
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_q, last_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;
    logic       rel_c;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [15:0] hold_q, hold_d;
    logic [3:0]  others_c;
`else
    logic unused_max_hold;
    assign unused_max_hold = (MAX_HOLD > 1);
`endif

    // Scan last+1 .. last+4 so the previous winner is considered last.
    function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && mask[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign rel_c = done[sel_q] | ~req[sel_q];

    always_comb begin
        logic [1:0] w;
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        last_d    = last_q;
        timeout_d = 1'b0;
        w         = rr_pick(req, last_q);
`ifdef BUS_ARB_TIMEOUT_EN
        hold_d   = hold_q + 16'd1;
        others_c = req & ~grant_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef BUS_ARB_TIMEOUT_EN
                hold_d = '0;
`endif
                if (|req) begin
                    grant_d = 4'b0001 << w;
                    sel_d   = w;
                    busy_d  = 1'b1;
                    last_d  = w;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (rel_c) begin
`ifdef BUS_ARB_TIMEOUT_EN
                    hold_d = '0;
`endif
                    if (|req) begin
                        grant_d = 4'b0001 << w;
                        sel_d   = w;
                        last_d  = w;
                    end else begin
                        grant_d = 4'b0000;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (hold_q == 16'(MAX_HOLD - 1)) begin
                    // Forced release only hands over when someone else is waiting.
                    hold_d = '0;
                    if (|others_c) begin
                        w         = rr_pick(others_c, last_q);
                        grant_d   = 4'b0001 << w;
                        sel_d     = w;
                        last_d    = w;
                        timeout_d = 1'b1;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            sel_q     <= 2'd0;
            last_q    <= 2'd3;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    always_comb begin
        dout = '0;
        if (busy_q) begin
            case (sel_q)
                2'd0:    dout = din0;
                2'd1:    dout = din1;
                2'd2:    dout = din2;
                default: dout = din3;
            endcase
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// tb/tb_bus_arbiter4.sv - self-checking bench for bus_arbiter4 against a transaction-level model
module tb_bus_arbiter4;

    localparam int W  = 32;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req, done;
    logic [W-1:0] din0, din1, din2, din3, dout;
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic         busy, timeout;

    int vectors = 0;
    int errors  = 0;

    bus_arbiter4 #(.WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .dout(dout), .grant(grant), .sel(sel), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner index (-1 = idle), last winner, cycles owned since grant.
    int         m_owner, m_last, m_owned, m_sel;
    bit         m_to;
    logic [3:0] m_mask;

    task automatic m_grant(input logic [3:0] mask);
        for (int i = 1; i <= 4; i++) begin
            if (mask[(m_last + i) % 4]) begin
                m_owner = (m_last + i) % 4;
                break;
            end
        end
        m_last  = m_owner;
        m_sel   = m_owner;
        m_owned = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_last = 3; m_owned = 0; m_sel = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_owner < 0) begin
                if (req != 0) m_grant(req);
            end else begin
                m_owned++;
                if (done[m_owner] || !req[m_owner]) begin
                    if (req != 0) m_grant(req);
                    else m_owner = -1;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (m_owned == MH) begin
                    m_mask = req;
                    m_mask[m_owner] = 1'b0;
                    if (m_mask != 0) begin
                        m_grant(m_mask);
                        m_to = 1;
                    end else begin
                        m_owned = 0;
                    end
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [W-1:0] ed;
            case (m_owner)
                0: ed = din0;
                1: ed = din1;
                2: ed = din2;
                3: ed = din3;
                default: ed = '0;
            endcase
            chk("cyc_grant", grant, (m_owner < 0) ? 4'b0 : (4'b0001 << m_owner));
            chk("cyc_sel", sel, m_sel[1:0]);
            chk("cyc_busy", busy, m_owner >= 0);
            chk("cyc_dout", dout, ed);
            chk("cyc_timeout", timeout, m_to);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] exp_seq [5];
    logic [1:0] exp_sel [5];

    initial begin
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst_n = 1'b0; req = 4'b0; done = 4'b0;
        din0 = 32'hA5A5_0000; din1 = 32'hA5A5_0001; din2 = 32'hA5A5_0002; din3 = 32'hA5A5_0003;
        tick(); tick();
        chk("rst_grant", grant, 4'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sel", sel, 2'd0);
        chk("rst_timeout", timeout, 1'b0);
        rst_n = 1'b1;
        tick();

        // All four requesting, each owner finishes after three cycles.
        req = 4'b1111;
        tick();
        for (int n = 0; n < 5; n++) begin
            chk("rr_grant", grant, exp_seq[n]);
            chk("rr_sel", sel, exp_sel[n]);
            chk("rr_busy", busy, 1'b1);
            if (n < 4) begin
                tick(); tick();
                done = grant;
                tick();
                done = 4'b0;
            end
        end
        req = 4'b0;
        tick();
        chk("rr_idle", busy, 1'b0);

        // Single requester, data steering and return to idle.
        req = 4'b0100;
        tick();
        chk("one_grant", grant, 4'b0100);
        chk("one_sel", sel, 2'd2);
        chk("one_dout", dout, 32'hA5A5_0002);
        done = 4'b0100; req = 4'b0;
        tick();
        done = 4'b0;
        chk("one_rel_grant", grant, 4'b0);
        chk("one_rel_busy", busy, 1'b0);
        chk("one_rel_dout", dout, 32'h0);
        chk("one_rel_sel", sel, 2'd2);

        // Non-owner done and late request do not disturb owner 1.
        req = 4'b0010;
        tick();
        chk("own1_grant", grant, 4'b0010);
        req = 4'b1010; done = 4'b1000;
        tick();
        done = 4'b0;
        chk("own1_hold", grant, 4'b0010);
        tick();
        done = 4'b0010;
        tick();
        done = 4'b0;
        chk("own1_handoff", grant, 4'b1000);
        chk("own1_handoff_sel", sel, 2'd3);
        req = 4'b0;
        tick();

        // Asynchronous reset mid-transaction.
        req = 4'b0100;
        tick();
        chk("ar_pre", grant, 4'b0100);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_grant", grant, 4'b0);
        chk("ar_busy", busy, 1'b0);
        tick();
        req = 4'b1111; rst_n = 1'b1;
        tick();
        chk("ar_first", grant, 4'b0001);
        req = 4'b0;
        tick();

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b0011;
        tick();
        chk("to_start", grant, 4'b0001);
`ifdef BUS_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_hold", grant, 4'b0001);
            chk("to_quiet", timeout, 1'b0);
        end
        tick();
        chk("to_forced", grant, 4'b0010);
        chk("to_pulse", timeout, 1'b1);
        tick();
        chk("to_pulse_end", timeout, 1'b0);
        req = 4'b0;
        tick();
        req = 4'b0001;
        tick();
        repeat (20) tick();
        chk("to_sole_grant", grant, 4'b0001);
        chk("to_sole_timeout", timeout, 1'b0);
`else
        repeat (100) tick();
        chk("noto_grant", grant, 4'b0001);
        chk("noto_timeout", timeout, 1'b0);
`endif
        req = 4'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
